// File: rtl/gelato_warp_launcher.sv
// ---------------------------------------------------------------------------
// gelato_warp_launcher
//
// Kernel-init endpoint between the GPU launch logic and the split table.
// It accepts one launch request (start pc + signed worker count) and
// converts it into a stream of split-table entries, one per warp of
// WARP_SIZE threads. Each entry carries the warp slot index, the start pc
// and the mask of live lanes.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   init_valid    launch request strobe, one cycle per request
//   init_pc       kernel start pc
//   init_workers  signed total thread count
//   busy          launch in progress; new requests are rejected
//   warp_valid    split-table entry valid
//   warp_ready    split table accepts the entry
//   warp_id       warp slot index
//   warp_pc       start pc of the warp
//   warp_mask     live lanes of the warp (bit i = lane i)
//   launch_done   one-cycle pulse after the last entry is accepted
//   launch_err    one-cycle pulse when a request is rejected
// ---------------------------------------------------------------------------
module gelato_warp_launcher #(
   parameter int WARP_SIZE  = 32,
   parameter int NUM_WARPS  = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         init_valid,
   input  logic [ADDR_WIDTH-1:0]        init_pc,
   input  logic [31:0]                  init_workers,
   output logic                         busy,
   output logic                         warp_valid,
   input  logic                         warp_ready,
   output logic [$clog2(NUM_WARPS)-1:0] warp_id,
   output logic [ADDR_WIDTH-1:0]        warp_pc,
   output logic [WARP_SIZE-1:0]         warp_mask,
   output logic                         launch_done,
   output logic                         launch_err
);

   localparam int LOG_WS = $clog2(WARP_SIZE);
   localparam int ID_W   = $clog2(NUM_WARPS);
   // Warp count can reach NUM_WARPS itself, so it needs one extra bit.
   localparam int CNT_W  = ID_W + 1;
   // 33-bit limit so the positive 32-bit worker count never overflows.
   localparam logic [32:0] LIMIT = 33'(WARP_SIZE * NUM_WARPS);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   pc_reg;
   logic [CNT_W-1:0]        nwarps_reg;
   logic [LOG_WS-1:0]       rem_reg;
   logic [ID_W-1:0]         cnt_reg;
   logic                    err_reg;

   // Request classification. Sign bit set or zero means nothing to launch;
   // the over-limit test is only meaningful for positive counts.
   logic                    w_nonpos;
   logic                    w_over;
   logic                    accept;
   logic [CNT_W-1:0]        nwarps_calc;
   logic [LOG_WS-1:0]       rem_calc;

   assign w_nonpos = init_workers[31] || (init_workers == 32'd0);
   assign w_over   = ({1'b0, init_workers} > LIMIT);
   assign accept   = init_valid && (state_reg == IDLE) && !w_nonpos && !w_over;

   // ceil(W / WARP_SIZE) = (W >> LOG_WS) + (any low bit set). W is bounded by
   // the limit here, so the quotient fits in CNT_W bits.
   assign rem_calc    = init_workers[LOG_WS-1:0];
   assign nwarps_calc = init_workers[LOG_WS +: CNT_W] + CNT_W'(|rem_calc);

   logic last;
   logic handshake;
   logic partial_last;
   logic [WARP_SIZE-1:0] mask_calc;

   assign last         = ({1'b0, cnt_reg} == (nwarps_reg - CNT_W'(1)));
   assign handshake    = (state_reg == ISSUE) && warp_ready;
   assign partial_last = last && (rem_reg != '0);

   // Lane gi is live unless this is a short final warp and gi >= rem.
   genvar gi;
   generate
      for (gi = 0; gi < WARP_SIZE; gi++) begin : g_mask
         assign mask_calc[gi] = !partial_last || (rem_reg > LOG_WS'(gi));
      end
   endgenerate

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (init_valid) begin
               if (w_nonpos) begin
                  state_next = DONE;
               end else if (!w_over) begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (warp_ready && last) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- launch datapath ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_reg     <= '0;
         nwarps_reg <= '0;
         rem_reg    <= '0;
         cnt_reg    <= '0;
         err_reg    <= 1'b0;
      end else begin
         // Rejections: anything arriving while busy, or an oversized launch.
         err_reg <= init_valid && ((state_reg != IDLE) || (!w_nonpos && w_over));
         if (accept) begin
            pc_reg     <= init_pc;
            nwarps_reg <= nwarps_calc;
            rem_reg    <= rem_calc;
            cnt_reg    <= '0;
         end else if (handshake) begin
            cnt_reg <= cnt_reg + ID_W'(1);
         end
      end
   end

   // ---------------- outputs ----------------
   // Entry fields are driven only while issuing; they come straight from
   // registers, so they stay stable through backpressure.
   always_comb begin
      busy        = (state_reg != IDLE);
      warp_valid  = 1'b0;
      warp_id     = '0;
      warp_pc     = '0;
      warp_mask   = '0;
      launch_done = (state_reg == DONE);
      launch_err  = err_reg;
      if (state_reg == ISSUE) begin
         warp_valid = 1'b1;
         warp_id    = cnt_reg;
         warp_pc    = pc_reg;
         warp_mask  = mask_calc;
      end
   end

endmodule
